// File: rtl/serial_sub.sv
// serial_sub - bit-serial ripple-borrow subtractor.
//
// Computes O = (I0 - I1 - BIN) mod 2^WIDTH and BOUT = (I0 < I1 + BIN) one bit
// per clock using a single full-subtractor cell. Operands enter through a
// valid/ready handshake and the result leaves through a second one. Only one
// operation is in flight at a time.
//
// Ports:
//   CLK          rising-edge clock
//   ASYNCRESETN  asynchronous active-low reset
//   I_VALID      operand request valid
//   I_READY      block can accept operands (registered, high only in IDLE)
//   I0, I1       minuend / subtrahend, WIDTH bits, unsigned
//   BIN          borrow-in, captured together with I0/I1
//   O_VALID      result valid (registered, high only in DONE)
//   O_READY      consumer accepts the result
//   O            difference, WIDTH bits
//   BOUT         borrow-out
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic             I_VALID,
  output logic             I_READY,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic             BIN,
  output logic             O_VALID,
  input  logic             O_READY,
  output logic [WIDTH-1:0] O,
  output logic             BOUT
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Full-subtractor borrow: borrow when b exceeds a, or when they are equal
  // and a borrow is already pending.
  function automatic logic fs_borrow(input logic a, input logic b, input logic br);
    return (~a & b) | (~(a ^ b) & br);
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op0_q, op0_d;
  logic [WIDTH-1:0] op1_q, op1_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] o_q, o_d;
  logic             bout_q, bout_d;
  logic             i_ready_q, i_ready_d;
  logic             o_valid_q, o_valid_d;

  logic a_s;
  logic b_s;
  logic d_s;
  logic br_next_s;

  // Next-state and datapath computation for the serial subtract sequence.
  always_comb begin
    state_d   = state_q;
    op0_d     = op0_q;
    op1_d     = op1_q;
    res_d     = res_q;
    cnt_d     = cnt_q;
    br_d      = br_q;
    o_d       = o_q;
    bout_d    = bout_q;
    a_s       = op0_q[cnt_q];
    b_s       = op1_q[cnt_q];
    d_s       = a_s ^ b_s ^ br_q;
    br_next_s = fs_borrow(a_s, b_s, br_q);

    case (state_q)
      IDLE: begin
        if (I_VALID) begin
          op0_d   = I0;
          op1_d   = I1;
          br_d    = BIN;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // Result fills from the top so bit 0 lands in place after WIDTH shifts.
        res_d = {d_s, res_q[WIDTH-1:1]};
        br_d  = br_next_s;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          // Publish only the finished word, including the bit computed now.
          o_d     = res_d;
          bout_d  = br_next_s;
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (O_READY) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Handshake flags are decoded from the next state so they come out of flops.
    i_ready_d = (state_d == IDLE);
    o_valid_d = (state_d == DONE);
  end

  // State, operand, result and handshake registers.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q   <= IDLE;
      op0_q     <= '0;
      op1_q     <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
      br_q      <= 1'b0;
      o_q       <= '0;
      bout_q    <= 1'b0;
      i_ready_q <= 1'b1;
      o_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op0_q     <= op0_d;
      op1_q     <= op1_d;
      res_q     <= res_d;
      cnt_q     <= cnt_d;
      br_q      <= br_d;
      o_q       <= o_d;
      bout_q    <= bout_d;
      i_ready_q <= i_ready_d;
      o_valid_q <= o_valid_d;
    end
  end

  assign I_READY = i_ready_q;
  assign O_VALID = o_valid_q;
  assign O       = o_q;
  assign BOUT    = bout_q;

endmodule
